tx_tlp_fragmenter: RTL and testbench

// Downstream of the TX arbiter. Stores each granted TLP (header DWs followed by payload DWs) in a circular DW buffer.

---
 rtl/tx_tlp_fragmenter_pkg.sv | 16 +
 rtl/tx_tlp_fragmenter_len_fifo.sv | 44 ++++
 rtl/tx_tlp_fragmenter.sv | 211 +++++++++++++++++++++
 tb/tb_tx_tlp_fragmenter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_tlp_fragmenter_pkg.sv
// Shared constants and types for the TX TLP fragmenter.
// Defaults match the arbiter/DLL widths used on this link.
package tx_tlp_fragmenter_pkg;

    localparam int DW           = 32;
    localparam int DEF_IN_DW    = 8;
    localparam int DEF_OUT_DW   = 4;
    localparam int DEF_DEPTH_DW = 256;
    localparam int DEF_MAX_TLPS = 16;

    typedef enum logic {
        FRAG_IDLE,
        FRAG_SEND
    } frag_state_t;

endpackage

// File: rtl/tx_tlp_fragmenter_len_fifo.sv
// Length FIFO of committed TLPs, read first-word-fall-through.
// DEPTH must be a power of two.
module tlp_len_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       push,
    input  logic [W-1:0]               push_len,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge clk) begin
        if (arst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= push_len;
    end

    assign head  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count = CW'(wp - rp);

endmodule

// File: rtl/tx_tlp_fragmenter.sv
// Store-and-forward TLP buffer: arbiter beats in, DLL-sized fragments out.
// Only committed (eop-terminated) TLPs are released to the output FSM.
module tx_tlp_fragmenter
    import tx_tlp_fragmenter_pkg::*;
#(
    parameter int IN_DW    = DEF_IN_DW,
    parameter int OUT_DW   = DEF_OUT_DW,
    parameter int DEPTH_DW = DEF_DEPTH_DW,
    parameter int MAX_TLPS = DEF_MAX_TLPS
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic [$clog2(IN_DW+1)-1:0]    in_dw_cnt,
    input  logic [IN_DW*32-1:0]           in_data,
    output logic [$clog2(DEPTH_DW+1)-1:0] free_dw,
    output logic [$clog2(MAX_TLPS+1)-1:0] tlp_count,
    output logic                          dll_valid,
    input  logic                          dll_ready,
    output logic                          dll_sop,
    output logic                          dll_eop,
    output logic [$clog2(OUT_DW+1)-1:0]   dll_dw_cnt,
    output logic [OUT_DW*32-1:0]          dll_data,
    output logic                          err_seq
);

    localparam int AW = $clog2(DEPTH_DW);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(DEPTH_DW + 1);
    localparam int CW = $clog2(IN_DW + 1);
    localparam int OW = $clog2(OUT_DW + 1);
    localparam int TW = $clog2(MAX_TLPS + 1);

    logic [DW-1:0] mem [DEPTH_DW];

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_base, wr_nxt, rd_nxt, pend_ptr;
    logic [FW-1:0] len_acc, len_sum, pend_len, rem;
    logic          tlp_open, open_nxt, pend;
    logic          acc, wr_en, err_nxt, eop_hit;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0] fifo_head;
    logic [TW-1:0] fifo_count;

    frag_state_t          state;
    logic                 eop_done;
    logic [OW-1:0]        rd_adv, frag_cnt;
    logic [FW-1:0]        frag_rem;
    logic                 frag_eop;
    logic [OUT_DW*DW-1:0] frag_data;

    // A pending commit still owns a FIFO slot, so it gates in_ready too.
    assign in_ready = (free_dw >= FW'(IN_DW)) && !fifo_full
                   && ((fifo_count + TW'(pend)) < TW'(MAX_TLPS));

    always_comb begin
        acc      = in_valid && in_ready;
        wr_en    = 1'b0;
        wr_base  = wr_ptr;
        len_sum  = len_acc;
        err_nxt  = 1'b0;
        eop_hit  = 1'b0;
        open_nxt = tlp_open;
        wr_nxt   = wr_ptr;
        if (acc) begin
            if (in_dw_cnt == '0) begin
                err_nxt = 1'b1;
            end else if (in_sop) begin
                err_nxt = tlp_open;
                wr_en   = 1'b1;
                wr_base = tlp_open ? commit_ptr : wr_ptr;
                len_sum = FW'(in_dw_cnt);
            end else if (!tlp_open) begin
                err_nxt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                len_sum = len_acc + FW'(in_dw_cnt);
            end
            if (wr_en) begin
                wr_nxt   = wr_base + PW'(in_dw_cnt);
                eop_hit  = in_eop;
                open_nxt = !in_eop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < IN_DW; i++) begin
                if (CW'(i) < in_dw_cnt)
                    mem[AW'(wr_base + PW'(i))] <= in_data[i*DW +: DW];
            end
        end
    end

    assign eop_done = (state == FRAG_SEND) && dll_ready && dll_eop;
    assign rd_adv   = (state == FRAG_SEND && dll_ready) ? dll_dw_cnt : '0;
    assign rd_nxt   = rd_ptr + PW'(rd_adv);
    assign fifo_pop = !fifo_empty && ((state == FRAG_IDLE) || eop_done);

    // Next fragment: either the head of a freshly popped TLP or the rest of the current one.
    always_comb begin
        frag_rem  = fifo_pop ? fifo_head : (rem - FW'(dll_dw_cnt));
        frag_cnt  = (frag_rem >= FW'(OUT_DW)) ? OW'(OUT_DW) : OW'(frag_rem);
        frag_eop  = (frag_rem <= FW'(OUT_DW));
        frag_data = '0;
        for (int i = 0; i < OUT_DW; i++) begin
            if (OW'(i) < frag_cnt)
                frag_data[i*DW +: DW] = mem[AW'(rd_nxt + PW'(i))];
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            tlp_open   <= 1'b0;
            len_acc    <= '0;
            pend       <= 1'b0;
            pend_ptr   <= '0;
            pend_len   <= '0;
            err_seq    <= 1'b0;
            free_dw    <= FW'(DEPTH_DW);
            tlp_count  <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            tlp_open <= open_nxt;
            if (eop_hit)    len_acc <= '0;
            else if (wr_en) len_acc <= len_sum;
            pend     <= eop_hit;
            pend_ptr <= wr_nxt;
            pend_len <= len_sum;
            err_seq  <= err_nxt;
            if (pend) commit_ptr <= pend_ptr;
            free_dw  <= FW'(DEPTH_DW) - FW'(wr_nxt - rd_nxt);
            unique case ({pend, eop_done})
                2'b10:   tlp_count <= tlp_count + 1'b1;
                2'b01:   tlp_count <= tlp_count - 1'b1;
                default: tlp_count <= tlp_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= FRAG_IDLE;
            rd_ptr     <= '0;
            rem        <= '0;
            dll_valid  <= 1'b0;
            dll_sop    <= 1'b0;
            dll_eop    <= 1'b0;
            dll_dw_cnt <= '0;
            dll_data   <= '0;
        end else begin
            unique case (state)
                FRAG_IDLE: begin
                    if (fifo_pop) begin
                        state      <= FRAG_SEND;
                        dll_valid  <= 1'b1;
                        dll_sop    <= 1'b1;
                        dll_eop    <= frag_eop;
                        dll_dw_cnt <= frag_cnt;
                        dll_data   <= frag_data;
                        rem        <= frag_rem;
                    end
                end
                FRAG_SEND: begin
                    if (dll_ready) begin
                        rd_ptr <= rd_nxt;
                        if (dll_eop && !fifo_pop) begin
                            state      <= FRAG_IDLE;
                            dll_valid  <= 1'b0;
                            dll_sop    <= 1'b0;
                            dll_eop    <= 1'b0;
                            dll_dw_cnt <= '0;
                            dll_data   <= '0;
                            rem        <= '0;
                        end else begin
                            dll_sop    <= fifo_pop;
                            dll_eop    <= frag_eop;
                            dll_dw_cnt <= frag_cnt;
                            dll_data   <= frag_data;
                            rem        <= frag_rem;
                        end
                    end
                end
                default: state <= FRAG_IDLE;
            endcase
        end
    end

    tlp_len_fifo #(
        .DEPTH (MAX_TLPS),
        .W     (FW)
    ) u_len_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (pend),
        .push_len (pend_len),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_tx_tlp_fragmenter.sv
// Directed + randomized bench for tx_tlp_fragmenter.
// Expected fragments come from a TLP-level queue model of committed traffic.
module tb_tx_tlp_fragmenter;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic [3:0]   in_dw_cnt = '0;
    logic [255:0] in_data = '0;
    logic [8:0]   free_dw;
    logic [4:0]   tlp_count;
    logic         dll_valid;
    logic         dll_ready = 1'b0;
    logic         dll_sop;
    logic         dll_eop;
    logic [2:0]   dll_dw_cnt;
    logic [127:0] dll_data;
    logic         err_seq;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    logic [31:0] exp_dw[$];
    int          exp_len[$];
    logic [31:0] m_part[$];
    bit          m_open = 1'b0;
    int          cur_rem = 0;
    bit          hold_q = 1'b0;
    logic [132:0] snap;

    tx_tlp_fragmenter dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_dw_cnt  (in_dw_cnt),
        .in_data    (in_data),
        .free_dw    (free_dw),
        .tlp_count  (tlp_count),
        .dll_valid  (dll_valid),
        .dll_ready  (dll_ready),
        .dll_sop    (dll_sop),
        .dll_eop    (dll_eop),
        .dll_dw_cnt (dll_dw_cnt),
        .dll_data   (dll_data),
        .err_seq    (err_seq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       dll_ready = 1'b0;
            1:       dll_ready = 1'b1;
            default: dll_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit_model();
        exp_len.push_back(m_part.size());
        foreach (m_part[i]) exp_dw.push_back(m_part[i]);
        m_part.delete();
    endtask

    // Drive one beat; returns ok=0 if in_ready never rose within limit cycles.
    task automatic beat(input bit sop, input bit eop, input int cnt,
                        input int limit, output bit ok);
        logic [255:0] d;
        bit e;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        in_sop = sop; in_eop = eop; in_dw_cnt = 4'(cnt); in_data = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < limit; w++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ok) begin
            e = 1'b0;
            if (cnt == 0) begin
                e = 1'b1;
            end else if (sop || m_open) begin
                e = sop && m_open;
                if (sop) m_part.delete();
                for (int i = 0; i < cnt; i++) m_part.push_back(d[i*32 +: 32]);
                m_open = !eop;
                if (eop) commit_model();
            end else begin
                e = 1'b1;
            end
            chk("err_seq", err_seq, e);
        end
    endtask

    task automatic send_tlp(input int len);
        int r = len;
        int c;
        bit first = 1'b1;
        bit ok;
        while (r > 0) begin
            c = $urandom_range(1, 8);
            if (c > r) c = r;
            beat(first, r == c, c, 300, ok);
            chk("beat_accept", ok, 1);
            first = 1'b0;
            r -= c;
        end
    endtask

    task automatic drain(input int limit);
        int w;
        for (w = 0; w < limit; w++) begin
            @(negedge clk);
            if (exp_len.size() == 0 && cur_rem == 0 && tlp_count == 0 && !dll_valid)
                break;
        end
        chk("drain_done", w < limit, 1);
        @(posedge clk); #1;
        chk("drain_free_dw", free_dw, 256);
        chk("drain_in_ready", in_ready, 1);
    endtask

    always @(negedge clk) begin
        int ecnt;
        logic [127:0] ed;
        if (arst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", dll_valid, 1);
                chk("hold_frag", {dll_sop, dll_eop, dll_dw_cnt, dll_data}, snap);
            end
            hold_q = dll_valid && !dll_ready;
            snap   = {dll_sop, dll_eop, dll_dw_cnt, dll_data};
            if (dll_valid && dll_ready) begin
                if (cur_rem == 0) begin
                    chk("frag_expected", exp_len.size() != 0, 1);
                    if (exp_len.size() != 0) cur_rem = exp_len.pop_front();
                    chk("frag_sop_first", dll_sop, 1);
                end else begin
                    chk("frag_sop_mid", dll_sop, 0);
                end
                if (cur_rem > 0) begin
                    ecnt = (cur_rem < 4) ? cur_rem : 4;
                    chk("frag_cnt", dll_dw_cnt, ecnt);
                    chk("frag_eop", dll_eop, cur_rem <= 4);
                    ed = '0;
                    for (int i = 0; i < ecnt; i++)
                        if (exp_dw.size() != 0) ed[i*32 +: 32] = exp_dw.pop_front();
                    chk("frag_data", dll_data, ed);
                    cur_rem -= ecnt;
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n_acc;
        int w;

        // Reset
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("rst_free_dw", free_dw, 256);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dll_valid", dll_valid, 0);
        chk("rst_tlp_count", tlp_count, 0);
        chk("rst_err_seq", err_seq, 0);
        @(posedge clk); #1;

        // 11-DW TLP, latency to first fragment
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        beat(1, 0, 8, 50, ok);
        chk("t2_beat0", ok, 1);
        beat(0, 1, 3, 50, ok);
        chk("t2_beat1", ok, 1);
        @(negedge clk);
        chk("lat_n0", dll_valid, 0);
        @(negedge clk);
        chk("lat_n1", dll_valid, 0);
        @(negedge clk);
        chk("lat_n2_valid", dll_valid, 1);
        chk("lat_n2_sop", dll_sop, 1);
        drain(200);

        // Back-pressure mid-TLP
        rdy_mode = 0;
        beat(1, 0, 8, 50, ok);
        beat(0, 1, 8, 50, ok);
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (dll_valid) break;
        end
        chk("bp_valid_seen", dll_valid, 1);
        @(posedge clk); #1 rdy_mode = 1;
        @(posedge clk); #1 rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_tlp_count", tlp_count, 1);
        chk("bp_valid_held", dll_valid, 1);
        chk("bp_sop_mid", dll_sop, 0);
        rdy_mode = 1;
        drain(200);

        // Fill with 8-DW TLPs while the DLL stalls
        rdy_mode = 0;
        n_acc = 0;
        for (int k = 0; k < 32; k++) begin
            beat(1, 1, 8, 20, ok);
            if (!ok) break;
            n_acc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("fill_accepted", n_acc, 17);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_free_dw", free_dw, 256 - 8 * n_acc);
        chk("fill_tlp_count", tlp_count, n_acc);
        rdy_mode = 2;
        drain(2000);

        // Framing errors
        rdy_mode = 1;
        beat(1, 0, 8, 50, ok);
        beat(1, 1, 4, 50, ok);
        @(posedge clk); #1;
        chk("frm_err_pulse_end", err_seq, 0);
        beat(0, 1, 5, 50, ok);
        beat(1, 1, 0, 50, ok);
        @(posedge clk); #1;
        chk("frm_err_clear", err_seq, 0);
        drain(200);

        // Back-to-back single-fragment TLPs
        rdy_mode = 0;
        beat(1, 1, 4, 50, ok);
        beat(1, 1, 4, 50, ok);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_tlp_count", tlp_count, 2);
        rdy_mode = 1;
        for (w = 0; w < 20; w++) begin
            @(negedge clk);
            if (dll_valid && dll_ready) break;
        end
        chk("b2b_first_sop_eop", {dll_valid, dll_sop, dll_eop}, 3'b111);
        @(negedge clk);
        chk("b2b_second_sop_eop", {dll_valid, dll_sop, dll_eop}, 3'b111);
        drain(200);

        // Random traffic, wraps the buffer several times
        rdy_mode = 2;
        for (int t = 0; t < 40; t++) send_tlp($urandom_range(1, 40));
        drain(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
